if_fetch_ir: RTL

- Instruction-fetch stage of the multi-cycle CPU: owns the PC, issues word fetches to instruction memory over a req/ready handshake, and latches the returned word into the instruction register (IR).
- Feeds the ID stage: the latched instruction drives the ID-stage immediate extension and the register-file address fields.
- Holds the instruction stable until ID acknowledges it. Accepts PC redirects (branch/jump) from the main controller.

---
 rtl/cpu_defs_pkg.sv | 18 +
 rtl/if_fetch_ir_pc_reg.sv | 62 ++++++
 rtl/if_fetch_ir.sv | 100 ++++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: fetch FSM encoding, word size and the NOP word.
package cpu_defs;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FULL = 2'd2
  } fetch_state_t;

  localparam logic [31:0] WORD_BYTES = 32'd4;
  localparam logic [31:0] NOP_WORD   = 32'h0000_0000;

  // Force an address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_ir_pc_reg.sv
// Program counter with a pending-redirect slot.
// While a fetch is outstanding the PC must stay put (it is the fetch
// address), so a redirect is parked and applied when the fetch is accepted.
module pc_reg
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_req,
  input  logic        accept,
  input  logic        pc_wr,
  input  logic [31:0] pc_next,
  output logic [31:0] pc
);

  logic [31:0] pend_pc;
  logic        pend_valid;
  logic [31:0] pc_d;
  logic [31:0] pend_pc_d;
  logic        pend_valid_d;

  // Choose the next PC: a same-cycle redirect beats a parked one, which beats pc+4.
  always_comb begin
    pc_d         = pc;
    pend_pc_d    = pend_pc;
    pend_valid_d = pend_valid;
    if (accept) begin
      if (pc_wr) begin
        pc_d = word_align(pc_next);
      end else if (pend_valid) begin
        pc_d = pend_pc;
      end else begin
        pc_d = pc + WORD_BYTES;
      end
      pend_valid_d = 1'b0;
      pend_pc_d    = 32'h0000_0000;
    end else if (in_req) begin
      if (pc_wr) begin
        pend_pc_d    = word_align(pc_next);
        pend_valid_d = 1'b1;
      end
    end else if (pc_wr) begin
      pc_d = word_align(pc_next);
    end
  end

  // PC and pending-redirect registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      pend_pc    <= 32'h0000_0000;
      pend_valid <= 1'b0;
    end else begin
      pc         <= pc_d;
      pend_pc    <= pend_pc_d;
      pend_valid <= pend_valid_d;
    end
  end

endmodule

// File: rtl/if_fetch_ir.sv
// Instruction-fetch stage: fetch FSM, instruction register and memory timeout.
module if_fetch_ir
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_start,
  input  logic        pc_wr,
  input  logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        id_ack,
  output logic [31:0] pc,
  output logic        fetch_busy,
  output logic        fetch_err
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYC);

  fetch_state_t state;
  fetch_state_t state_d;
  logic         accept;
  logic         in_req;
  logic [7:0]   to_cnt;

  assign in_req     = (state == S_REQ);
  assign accept     = in_req && imem_ready;
  assign imem_req   = in_req;
  assign fetch_busy = in_req;
  assign imem_addr  = pc;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .in_req  (in_req),
    .accept  (accept),
    .pc_wr   (pc_wr),
    .pc_next (pc_next),
    .pc      (pc)
  );

  // Fetch FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state: a full IR only moves on when ID acknowledges it.
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE: if (fetch_start) state_d = S_REQ;
      S_REQ:  if (imem_ready)  state_d = S_FULL;
      S_FULL: if (id_ack)      state_d = fetch_start ? S_REQ : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Instruction register: capture on acceptance, release on ID acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr       <= NOP_WORD;
      instr_pc    <= 32'h0000_0000;
      instr_valid <= 1'b0;
    end else if (accept) begin
      instr       <= imem_rdata;
      instr_pc    <= pc;
      instr_valid <= 1'b1;
    end else if (state == S_FULL && id_ack) begin
      instr_valid <= 1'b0;
    end
  end

  // Count stalled request cycles; raise a sticky error once the limit is hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt    <= 8'd0;
      fetch_err <= 1'b0;
    end else if (in_req && !imem_ready) begin
      if (to_cnt < TO_LIMIT) to_cnt <= to_cnt + 8'd1;
      if (to_cnt >= TO_LIMIT - 8'd1) fetch_err <= 1'b1;
    end else begin
      to_cnt <= 8'd0;
    end
  end

endmodule
